// File: rtl/mem_sram_ctrl_if.sv
// Load/store request bus between the EX/MEM pipeline register and the SRAM memory stage.
interface mem_sram_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-stage responder: splits each 32-bit load/store into two 16-bit transfers
// on an external asynchronous SRAM, stalling the pipeline through ready.
//
// state | meaning
// IDLE  | no access outstanding; a request is accepted here
// LOW   | low half-word on the SRAM pins for SRAM_WAIT cycles
// HIGH  | high half-word on the SRAM pins for SRAM_WAIT cycles
// DONE  | access complete, ready high for one cycle
module mem_sram_ctrl #(
    parameter int          SRAM_WAIT = 3,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_sram_ctrl_if.slave        bus,
    output logic [17:0]           sram_addr,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [15:0]           sram_dq_in,
    output logic                  sram_we_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] TC = 4'(SRAM_WAIT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] rdata;
    logic [31:0] off;
    logic [16:0] word;
    logic        req, is_write, is_read, tc_hit;
    logic        ready;
    logic [17:0] addr_nxt;
    logic [15:0] dq_nxt;
    logic        oe_nxt, we_n_nxt;
    logic        unused_off;

    // Requester holds its inputs stable while ready is low, so they are used live.
    assign req      = bus.rd_en | bus.wr_en;
    assign is_write = bus.wr_en;
    assign is_read  = bus.rd_en & ~bus.wr_en;
    assign tc_hit   = (cnt == TC);

    assign off        = bus.address - BASE_ADDR;
    assign word       = off[18:2];
    assign unused_off = ^{off[31:19], off[1:0]};

    assign bus.read_data = rdata;
    assign bus.ready     = ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            rdata       <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sram_addr   <= addr_nxt;
            sram_dq_out <= dq_nxt;
            sram_dq_oe  <= oe_nxt;
            sram_we_n   <= we_n_nxt;
            if (is_read && tc_hit && state == LOW)
                rdata[15:0] <= sram_dq_in;
            if (is_read && tc_hit && state == HIGH)
                rdata[31:16] <= sram_dq_in;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LOW;
                    cnt_nxt   = 4'd0;
                end
            end
            LOW: begin
                if (tc_hit) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (tc_hit) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // SRAM pins are registered, so they are derived from the upcoming state and count.
    // The strobe rises on the last cycle of each phase to hold data past the edge.
    always_comb begin
        ready    = (state == IDLE && !req) || state == DONE;
        addr_nxt = sram_addr;
        dq_nxt   = sram_dq_out;
        oe_nxt   = 1'b0;
        we_n_nxt = 1'b1;
        if (state_nxt == LOW || state_nxt == HIGH) begin
            addr_nxt = {word, state_nxt == HIGH};
            if (is_write) begin
                dq_nxt   = (state_nxt == HIGH) ? bus.write_data[31:16] : bus.write_data[15:0];
                oe_nxt   = 1'b1;
                we_n_nxt = (SRAM_WAIT > 1) && (cnt_nxt == TC);
            end
        end
    end

endmodule
